// File: rtl/pixel_frame_loader_if.sv
// Stream and frame handshake bundle for pixel_frame_loader.
// master: pixel source plus frame consumer. slave: the loader.
interface pixel_frame_loader_if #(
  parameter int unsigned tam    = 16,
  parameter int unsigned in_qnt = 784
);
  logic [7:0]                  s_data;
  logic                        s_valid;
  logic                        s_ready;
  logic [(in_qnt+1)*tam-1:0]   frame_vec;
  logic                        frame_valid;
  logic                        frame_ack;

  modport master (
    output s_data, s_valid, frame_ack,
    input  s_ready, frame_vec, frame_valid
  );

  modport slave (
    input  s_data, s_valid, frame_ack,
    output s_ready, frame_vec, frame_valid
  );
endinterface

// File: rtl/pixel_frame_loader.sv
// Loads a serial stream of 8-bit pixels into the neuron input vector as
// half-precision values (pixel/256). Entry 0 is the fixed bias 1.0.
module pixel_frame_loader #(
  parameter  int unsigned tam    = 16,
  parameter  int unsigned in_qnt = 784,
  localparam int unsigned CW     = $clog2(in_qnt + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  pixel_frame_loader_if.slave  bus,
  output logic [CW-1:0]        pix_count
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     pix_q, pix_d;
  logic [tam-1:0]    ent_q [0:in_qnt-1];  // ent_q[i] holds vector entry i+1
  logic              we;
  logic [15:0]       pix_conv;
  logic [(in_qnt+1)*tam-1:0] vec;

  // Exact unsigned 8-bit to half conversion: exponent from the MSB index,
  // mantissa is the bits below the MSB left-aligned in the 10-bit field.
  function automatic logic [15:0] conv(input logic [7:0] p);
    logic [2:0]  k;
    logic [17:0] sh;
    logic [15:0] r;
    k = '0;
    r = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      if (p[b]) k = 3'(b);
    end
    sh = {10'b0, p} << (5'd10 - {2'b0, k});
    if (p != 8'd0) r = {1'b0, {2'b0, k} + 5'd7, sh[9:0]};
    return r;
  endfunction

  // Pixel conversion and write strobe (abort discards the transfer)
  always_comb begin
    pix_conv = conv(bus.s_data);
    we       = (state_q == LOAD) && bus.s_valid && !abort;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d         = state_q;
    pix_d           = pix_q;
    bus.s_ready     = (state_q == LOAD);
    bus.frame_valid = (state_q == DONE);
    if (abort) begin
      state_d = IDLE;
      pix_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = LOAD;
            pix_d   = '0;
          end
        end
        LOAD: begin
          if (bus.s_valid) begin
            pix_d = pix_q + 1'b1;
            if (pix_q == CW'(in_qnt - 1)) state_d = DONE;
          end
        end
        DONE: begin
          if (bus.frame_ack) begin
            state_d = start ? LOAD : IDLE;
            if (start) pix_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          pix_d   = '0;
        end
      endcase
    end
  end

  // State and pixel counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
    end
  end

  // Vector entry storage: one entry written per accepted pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < in_qnt; i++) ent_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < in_qnt; i++) begin
        if (we && (pix_q == CW'(i))) ent_q[i] <= tam'(pix_conv);
      end
    end
  end

  // Flatten the entries with the constant bias in slot 0
  always_comb begin
    vec          = '0;
    vec[tam-1:0] = tam'(16'h3C00);
    for (int unsigned i = 0; i < in_qnt; i++) begin
      vec[(i+1)*tam +: tam] = ent_q[i];
    end
  end

  assign bus.frame_vec = vec;
  assign pix_count     = pix_q;

endmodule

// File: tb/tb_pixel_frame_loader.sv
// Scoreboard bench for pixel_frame_loader with a 4-pixel frame.
module tb_pixel_frame_loader;

  localparam int unsigned TAM = 16;
  localparam int unsigned NQ  = 4;
  localparam int unsigned CW  = $clog2(NQ + 1);

  typedef struct {
    int          idx;
    logic [15:0] val;
  } sb_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [CW-1:0] pix_count;

  int          checks;
  int          failures;
  int          exp_cnt;
  logic [15:0] model [1:NQ];
  sb_t         sb_q [$];

  pixel_frame_loader_if #(.tam(TAM), .in_qnt(NQ)) bus ();

  pixel_frame_loader #(.tam(TAM), .in_qnt(NQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .bus       (bus),
    .pix_count (pix_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference conversion: normalise by shifting left until bit 7 is set.
  function automatic logic [15:0] ref_conv(input logic [7:0] p);
    logic [7:0] m;
    int         s;
    if (p == 8'd0) return 16'h0000;
    m = p;
    s = 0;
    while (!m[7]) begin
      m = m << 1;
      s++;
    end
    return {1'b0, 5'(14 - s), m[6:0], 3'b000};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one pixel; accepted pixels go to the scoreboard and are
  // compared once the DUT exposes them after the edge.
  task automatic xfer(input logic [7:0] p, input logic v, input logic exp_rdy);
    sb_t e;
    bus.s_data  = p;
    bus.s_valid = v;
    #1;
    checks++;
    if (bus.s_ready !== exp_rdy) begin
      failures++;
      $display("FAIL xfer_s_ready got=%0b exp=%0b", bus.s_ready, exp_rdy);
    end
    if (v && exp_rdy) begin
      exp_cnt++;
      model[exp_cnt] = ref_conv(p);
      sb_q.push_back('{exp_cnt, ref_conv(p)});
    end
    tick();
    bus.s_valid = 1'b0;
    bus.s_data  = 8'hAA;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (bus.frame_vec[e.idx*TAM +: TAM] !== e.val) begin
        failures++;
        $display("FAIL sb_entry%0d got=%h exp=%h", e.idx, bus.frame_vec[e.idx*TAM +: TAM], e.val);
      end
    end
    checks++;
    if (pix_count !== CW'(exp_cnt)) begin
      failures++;
      $display("FAIL xfer_pix_count got=%0d exp=%0d", pix_count, exp_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.frame_vec[0 +: TAM] !== 16'h3C00) begin
      failures++;
      $display("FAIL reset_entry0 got=%h exp=3c00", bus.frame_vec[0 +: TAM]);
    end
    for (int i = 1; i <= NQ; i++) begin
      checks++;
      if (bus.frame_vec[i*TAM +: TAM] !== 16'h0000) begin
        failures++;
        $display("FAIL reset_entry%0d got=%h exp=0000", i, bus.frame_vec[i*TAM +: TAM]);
      end
    end
    checks++;
    if ({bus.s_ready, bus.frame_valid} !== 2'b00 || pix_count !== '0) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b fv=%b cnt=%0d exp 0 0 0", bus.s_ready, bus.frame_valid, pix_count);
    end
  endtask

  task automatic test_basic();
    logic [7:0]  px  [4] = '{8'd0, 8'd1, 8'd128, 8'd255};
    logic [15:0] lit [4] = '{16'h0000, 16'h1C00, 16'h3800, 16'h3BF8};
    pulse_start();
    exp_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      xfer(px[i], 1'b1, 1'b1);
      checks++;
      if (bus.frame_valid !== (i == 3)) begin
        failures++;
        $display("FAIL basic_frame_valid after px%0d got=%b exp=%b", i, bus.frame_valid, (i == 3));
      end
    end
    for (int i = 1; i <= NQ; i++) begin
      checks++;
      if (bus.frame_vec[i*TAM +: TAM] !== lit[i-1]) begin
        failures++;
        $display("FAIL basic_entry%0d got=%h exp=%h", i, bus.frame_vec[i*TAM +: TAM], lit[i-1]);
      end
    end
    checks++;
    if (bus.frame_vec[0 +: TAM] !== 16'h3C00) begin
      failures++;
      $display("FAIL basic_entry0 got=%h exp=3c00", bus.frame_vec[0 +: TAM]);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0]                  px  [7] = '{8'd3, 8'd0, 8'd200, 8'd0, 8'd2, 8'd0, 8'd5};
    logic [15:0]                 lit [4] = '{16'h2200, 16'h3A40, 16'h2000, 16'h2500};
    logic [(NQ+1)*TAM-1:0]       snap;
    bus.frame_ack = 1'b1;
    tick();
    bus.frame_ack = 1'b0;
    checks++;
    if (bus.frame_valid !== 1'b0 || bus.s_ready !== 1'b0) begin
      failures++;
      $display("FAIL ack_to_idle got fv=%b rdy=%b exp 0 0", bus.frame_valid, bus.s_ready);
    end
    pulse_start();
    exp_cnt = 0;
    for (int i = 0; i < 7; i++) xfer(px[i], (i % 2 == 0), 1'b1);
    for (int i = 1; i <= NQ; i++) begin
      checks++;
      if (bus.frame_vec[i*TAM +: TAM] !== lit[i-1]) begin
        failures++;
        $display("FAIL bubble_entry%0d got=%h exp=%h", i, bus.frame_vec[i*TAM +: TAM], lit[i-1]);
      end
    end
    snap = bus.frame_vec;
    for (int i = 0; i < 2; i++) xfer(8'd77, 1'b1, 1'b0);
    checks++;
    if (bus.frame_vec !== snap || bus.frame_valid !== 1'b1) begin
      failures++;
      $display("FAIL done_stable got fv=%b vec_changed=%b exp fv=1 unchanged", bus.frame_valid, bus.frame_vec !== snap);
    end
  endtask

  task automatic test_ack_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (bus.frame_valid !== 1'b1 || bus.s_ready !== 1'b0 || pix_count !== CW'(NQ)) begin
      failures++;
      $display("FAIL start_in_done got fv=%b rdy=%b cnt=%0d exp 1 0 %0d", bus.frame_valid, bus.s_ready, pix_count, NQ);
    end
    start         = 1'b1;
    bus.frame_ack = 1'b1;
    tick();
    start         = 1'b0;
    bus.frame_ack = 1'b0;
    checks++;
    if (bus.frame_valid !== 1'b0 || bus.s_ready !== 1'b1 || pix_count !== '0) begin
      failures++;
      $display("FAIL ack_start got fv=%b rdy=%b cnt=%0d exp 0 1 0", bus.frame_valid, bus.s_ready, pix_count);
    end
    exp_cnt = 0;
    xfer(8'd9, 1'b1, 1'b1);
    for (int i = 2; i <= NQ; i++) begin
      checks++;
      if (bus.frame_vec[i*TAM +: TAM] !== model[i]) begin
        failures++;
        $display("FAIL stale_entry%0d got=%h exp=%h", i, bus.frame_vec[i*TAM +: TAM], model[i]);
      end
    end
    // start and frame_ack are both ignored while loading
    start         = 1'b1;
    bus.frame_ack = 1'b1;
    tick();
    start         = 1'b0;
    bus.frame_ack = 1'b0;
    checks++;
    if (bus.s_ready !== 1'b1 || pix_count !== CW'(1)) begin
      failures++;
      $display("FAIL start_ack_in_load got rdy=%b cnt=%0d exp 1 1", bus.s_ready, pix_count);
    end
    xfer(8'd17, 1'b1, 1'b1);
    xfer(8'd64, 1'b1, 1'b1);
    xfer(8'd99, 1'b1, 1'b1);
    checks++;
    if (bus.frame_valid !== 1'b1) begin
      failures++;
      $display("FAIL ack_start_frame_valid got=%b exp=1", bus.frame_valid);
    end
  endtask

  task automatic test_abort();
    logic [15:0] old3;
    bus.frame_ack = 1'b1;
    tick();
    bus.frame_ack = 1'b0;
    pulse_start();
    exp_cnt = 0;
    xfer(8'd10, 1'b1, 1'b1);
    xfer(8'd20, 1'b1, 1'b1);
    old3        = model[3];
    abort       = 1'b1;
    bus.s_data  = 8'd255;
    bus.s_valid = 1'b1;
    tick();
    abort       = 1'b0;
    bus.s_valid = 1'b0;
    exp_cnt     = 0;
    checks++;
    if (bus.s_ready !== 1'b0 || bus.frame_valid !== 1'b0 || pix_count !== '0) begin
      failures++;
      $display("FAIL abort_state got rdy=%b fv=%b cnt=%0d exp 0 0 0", bus.s_ready, bus.frame_valid, pix_count);
    end
    checks++;
    if (bus.frame_vec[3*TAM +: TAM] !== old3) begin
      failures++;
      $display("FAIL abort_entry3 got=%h exp=%h", bus.frame_vec[3*TAM +: TAM], old3);
    end
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    checks++;
    if (bus.s_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_beats_start got rdy=%b exp=0", bus.s_ready);
    end
    pulse_start();
    for (int i = 0; i < NQ; i++) xfer(8'($urandom_range(255)), 1'b1, 1'b1);
    checks++;
    if (bus.frame_valid !== 1'b1 || pix_count !== CW'(NQ)) begin
      failures++;
      $display("FAIL abort_reload got fv=%b cnt=%0d exp 1 %0d", bus.frame_valid, pix_count, NQ);
    end
  endtask

  task automatic test_async_reset();
    bus.frame_ack = 1'b1;
    tick();
    bus.frame_ack = 1'b0;
    pulse_start();
    exp_cnt = 0;
    xfer(8'd33, 1'b1, 1'b1);
    xfer(8'd44, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.s_ready !== 1'b0 || bus.frame_valid !== 1'b0 || pix_count !== '0) begin
      failures++;
      $display("FAIL async_reset_outputs got rdy=%b fv=%b cnt=%0d exp 0 0 0", bus.s_ready, bus.frame_valid, pix_count);
    end
    checks++;
    if (bus.frame_vec[0 +: TAM] !== 16'h3C00) begin
      failures++;
      $display("FAIL async_reset_entry0 got=%h exp=3c00", bus.frame_vec[0 +: TAM]);
    end
    for (int i = 1; i <= NQ; i++) begin
      checks++;
      if (bus.frame_vec[i*TAM +: TAM] !== 16'h0000) begin
        failures++;
        $display("FAIL async_reset_entry%0d got=%h exp=0000", i, bus.frame_vec[i*TAM +: TAM]);
      end
    end
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    exp_cnt       = 0;
    start         = 1'b0;
    abort         = 1'b0;
    bus.s_data    = 8'h00;
    bus.s_valid   = 1'b0;
    bus.frame_ack = 1'b0;
    for (int i = 1; i <= NQ; i++) model[i] = 16'h0000;
    test_reset();
    test_basic();
    test_backpressure();
    test_ack_start();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_frame_loader.md
Name: pixel_frame_loader

Overview:
- Writer side of the neuron input vector: takes a serial stream of 8-bit unsigned pixels and converts each to half-precision (value = pixel/256).
- Packs the converted values into the flat (in_qnt+1)-entry input vector read by the neuron datapath.
- Entry 0 holds the constant bias 1.0 (0x3C00); entries 1..in_qnt hold pixels in arrival order.
- Handshakes a complete frame to the consumer with frame_valid/frame_ack.

Parameters:
tam, 16, word width of each vector entry (half-precision; block supports 16 only)
in_qnt, 784, pixels per frame; vector has in_qnt+1 entries

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins loading a new frame
abort  input  1  synchronous abort of the frame in progress
s_data  input  8  unsigned pixel
s_valid  input  1  pixel present on s_data
s_ready  output  1  loader accepts a pixel this cycle
frame_vec  output  (in_qnt+1)*tam  packed vector; entry i at bits [i*tam +: tam]
frame_valid  output  1  full frame loaded and stable
frame_ack  input  1  consumer has taken the frame
pix_count  output  $clog2(in_qnt+1)  pixels written in current frame (0..in_qnt)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; s_ready=0; frame_valid=0; pix_count=0.
  - Entry 0 = 0x3C00; entries 1..in_qnt = 0x0000.
- Entry 0 is never written by stream traffic; it reads 0x3C00 at all times.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: s_ready=0. start=1 -> LOAD, pix_count<=0.
  - LOAD: s_ready=1 (combinational from state). A transfer occurs when s_valid && s_ready at a rising edge. On each transfer, entry pix_count+1 <= conv(s_data) and pix_count++. The transfer that makes pix_count==in_qnt moves the FSM to DONE in the same edge, with frame_valid=1 from the next cycle.
  - DONE: s_ready=0; frame_valid=1; frame_vec stable. frame_ack=1 -> IDLE with frame_valid=0. frame_ack=1 and start=1 in the same cycle -> LOAD directly, with pix_count<=0 and frame_valid=0.
- Latency: a pixel accepted at edge N is visible in frame_vec after edge N. The last pixel and frame_valid both become visible after the same edge.
- conv(p), exact, combinational on s_data, no rounding:
  - p==0 -> 0x0000.
  - Otherwise k = index of MSB of p (0..7), and:
    - sign = 0
    - exponent = k+7
    - mantissa = (p << (10-k)) & 0x3FF
  - Examples: 1->0x1C00, 2->0x2000, 3->0x2200, 128->0x3800, 200->0x3A40, 255->0x3BF8.
- Entries not yet overwritten in the current frame keep their previous-frame values. The consumer reads only under frame_valid.
- Boundaries and precedence:
  - start in LOAD: ignored.
  - start in DONE without frame_ack: ignored.
  - frame_ack outside DONE: ignored.
  - s_valid while s_ready=0: no write, no count change; the source must hold data.
  - abort: highest priority after reset, valid in any state. Next state IDLE, pix_count=0, frame_valid=0, s_ready=0. A transfer presented in the abort cycle is discarded, so the vector is not written.
  - abort and start in the same cycle: abort wins, FSM goes to IDLE.
  - Reset mid-LOAD: all outputs and entries return to reset values immediately.
- pix_count never exceeds in_qnt; it holds in_qnt in DONE until the next start.
- Arithmetic widths: pix_count wraps never, because the FSM leaves LOAD at in_qnt. Conversion is 8-bit to 16-bit with no overflow possible.

Test Plan:
- Reset check: reset, release, in_qnt=4. Required: entry0=0x3C00, entries1..4=0, s_ready=0, frame_valid=0, pix_count=0.
- Basic frame: start, then pixels 0,1,128,255 with s_valid held high. Required: s_ready=1 for 4 cycles; entries1..4 = 0x0000, 0x1C00, 0x3800, 0x3BF8; frame_valid=1 after 4th edge; pix_count=4.
- Backpressure and bubbles:
  - s_valid toggled 1,0,1,0,... with data 3,_,200,_,2,_,5.
  - Required: only valid cycles write; entries = 0x2200, 0x3A40, 0x2000, 0x2500.
  - In DONE: s_valid=1 gives s_ready=0 and the vector is unchanged.
- Ack/start overlap:
  - In DONE, pulse frame_ack with start in the same cycle. Required: next cycle LOAD, frame_valid=0, pix_count=0.
  - Stale entries hold old values until overwritten.
  - start alone in DONE: no state change.
- Abort mid-frame: after 2 of 4 pixels, assert abort together with s_valid (data 255). Required: IDLE, pix_count=0, entry3 not written, s_ready=0; a following start reloads correctly.
- Async reset mid-LOAD: drop rst_n between clock edges. Required: outputs return to reset values before the next edge; entries1..in_qnt=0.
